// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
//   op_t     : operation select carried on the op port
//   state_t  : controller states
//   ITERATIONS : number of CALC cycles per operation (one bit per cycle)
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int ITERATIONS = 32;

    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the decoder/datapath and the
// multiply/divide unit.
//   start, op, in_s1, in_s2        : operation launch and operands
//   write_hi, write_lo, write_data : MTHI/MTLO strobes and data
//   busy, done, hi, lo             : status and architectural HI/LO
// master = issuing side, slave = muldiv_unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in_s1;
    logic [WIDTH-1:0] in_s2;
    logic             write_hi;
    logic             write_lo;
    logic [WIDTH-1:0] write_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, in_s1, in_s2, write_hi, write_lo, write_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, in_s1, in_s2, write_hi, write_lo, write_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_abs32.sv
// abs32: combinational conditional two's-complement negate.
//   in  : value to transform
//   neg : 1 = output -in, 0 = output in unchanged
//   out : result
// Used both for operand magnitudes and for the result sign fixups; the
// width parameter lets the same block negate the 64-bit product.
module abs32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);
    assign out = neg ? (~in + WIDTH'(1)) : in;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : muldiv_if.slave (start/op/operands, MTHI/MTLO, busy/done/hi/lo)
// Operations run on unsigned magnitudes for ITERATIONS cycles, then a single
// FIX cycle applies the sign corrections and writes HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clock,
    input  logic    reset_n,
    muldiv_if.slave bus
);

    state_t               state;
    state_t               state_nxt;
    logic [5:0]           count;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    op_t                  op_q;
    logic                 sign_a;
    logic                 sign_b;
    logic                 div_zero;
    logic [WIDTH-1:0]     operand_b;
    logic [2*WIDTH-1:0]   acc;

    logic                 signed_in;
    logic                 launch;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_diff;
    logic [2*WIDTH-1:0]   div_next;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     hi_res;
    logic [WIDTH-1:0]     lo_res;

    assign signed_in = is_signed_op(op_t'(bus.op));
    assign launch    = (state == S_IDLE) && bus.start;

    abs32 #(.WIDTH(WIDTH)) u_abs_a (
        .in  (bus.in_s1),
        .neg (signed_in && bus.in_s1[WIDTH-1]),
        .out (mag_a)
    );

    abs32 #(.WIDTH(WIDTH)) u_abs_b (
        .in  (bus.in_s2),
        .neg (signed_in && bus.in_s2[WIDTH-1]),
        .out (mag_b)
    );

    // sign_a/sign_b are only set for signed ops, so unsigned ops see no fixup.
    abs32 #(.WIDTH(2*WIDTH)) u_fix_prod (
        .in  (acc),
        .neg (sign_a ^ sign_b),
        .out (prod_fix)
    );

    abs32 #(.WIDTH(WIDTH)) u_fix_quot (
        .in  (acc[WIDTH-1:0]),
        .neg (sign_a ^ sign_b),
        .out (quot_fix)
    );

    abs32 #(.WIDTH(WIDTH)) u_fix_rem (
        .in  (acc[2*WIDTH-1:WIDTH]),
        .neg (sign_a),
        .out (rem_fix)
    );

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    // Add the multiplicand into the upper half when the current LSB is set,
    // then shift the whole accumulator right by one.
    // Divide step: acc = {partial remainder, remaining dividend / quotient}.
    // The shifted-in remainder can need WIDTH+1 bits, but when it is >= the
    // divisor the difference is always below the divisor, so WIDTH bits hold it.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, operand_b});
        rem_diff = rem_sh[WIDTH-1:0] - operand_b;
        div_next = rem_ge ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                          : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // On a zero divisor every trial subtraction succeeds, so the remainder
    // ends up as |in_s1| and its sign fixup restores the original in_s1;
    // only LO needs forcing to all ones.
    always_comb begin
        hi_res = prod_fix[2*WIDTH-1:WIDTH];
        lo_res = prod_fix[WIDTH-1:0];
        if (is_div_op(op_q)) begin
            hi_res = rem_fix;
            lo_res = div_zero ? '1 : quot_fix;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_CALC;
            S_CALC: if (count == 6'(ITERATIONS - 1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            count  <= '0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    count <= '0;
                    // start takes priority over a same-cycle MTHI/MTLO
                    if (!bus.start) begin
                        if (bus.write_hi) hi_q <= bus.write_data;
                        if (bus.write_lo) lo_q <= bus.write_data;
                    end
                end
                S_CALC: count <= count + 6'd1;
                S_FIX: begin
                    hi_q <= hi_res;
                    lo_q <= lo_res;
                end
                default: count <= '0;
            endcase
        end
    end

    // Operand/accumulator state is fully reloaded on every launch, so it
    // carries no reset.
    always_ff @(posedge clock) begin
        if (launch) begin
            op_q      <= op_t'(bus.op);
            sign_a    <= signed_in && bus.in_s1[WIDTH-1];
            sign_b    <= signed_in && bus.in_s2[WIDTH-1];
            div_zero  <= (bus.in_s2 == '0);
            operand_b <= mag_b;
            acc       <= {{WIDTH{1'b0}}, mag_a};
        end else if (state == S_CALC) begin
            acc <= is_div_op(op_q) ? div_next : mul_next;
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Expected {hi,lo} values
// are computed from the operands with native 64-bit arithmetic when an
// operation is issued, queued, and compared when done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin
                q = sa * sb;
                return q;
            end
            2'd1: begin
                p = {32'h0, a} * {32'h0, b};
                return p;
            end
            2'd2: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a falling edge; start is sampled at the next rising edge (N)
    // and the task returns at the falling edge just after N.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.op    = o;
        bus.in_s1 = a;
        bus.in_s2 = b;
        bus.start = 1'b1;
        sb_q.push_back(model(o, a, b));
        @(negedge clock);
        bus.start = 1'b0;
        bus.in_s1 = 32'hDEADBEEF;
        bus.in_s2 = 32'hCAFEF00D;
    endtask

    task automatic wait_done(output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b0;
        while (bus.done !== 1'b1) begin
            if (cycles >= 40) begin
                timed_out = 1'b1;
                return;
            end
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_multu_timing();
        int busy_cnt = 0;
        int done_cnt = 0;
        int first_done = -1;
        logic [63:0] got = '0;
        logic [63:0] exp;
        launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int m = 0; m < 40; m++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = m;
                    got = {bus.hi, bus.lo};
                end
            end
            if (m != 39) @(negedge clock);
        end
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL multu_max_result: got %h required %h", got, exp);
        end
        vectors++;
        if (busy_cnt != 33) begin
            miscompares++;
            $display("FAIL multu_busy_cycles: got %0d required 33", busy_cnt);
        end
        vectors++;
        if (done_cnt != 1 || first_done != 33) begin
            miscompares++;
            $display("FAIL multu_done_pulse: got count %0d at cycle %0d required 1 at 33",
                     done_cnt, first_done);
        end
    endtask

    task automatic test_ops(input string name, input logic [1:0] o,
                            input logic [31:0] a, input logic [31:0] b);
        int cyc;
        bit to;
        logic [63:0] exp;
        launch(o, a, b);
        wait_done(cyc, to);
        exp = sb_q.pop_front();
        vectors++;
        if (to || cyc != 33) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d cycles (timeout=%b) required 33", name, cyc, to);
        end
        vectors++;
        if ({bus.hi, bus.lo} !== exp) begin
            miscompares++;
            $display("FAIL %s_result: got hi=%h lo=%h required hi=%h lo=%h",
                     name, bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_multiply();
        test_ops("mult_neg3x7", 2'd0, 32'hFFFFFFFD, 32'd7);
        test_ops("mult_negxneg", 2'd0, 32'h80000000, 32'h80000000);
        for (int i = 0; i < 3; i++) begin
            test_ops("mult_rand", 2'd0, $urandom, $urandom);
            test_ops("multu_rand", 2'd1, $urandom, $urandom);
        end
    endtask

    task automatic test_divide();
        test_ops("div_neg7by2", 2'd2, 32'hFFFFFFF9, 32'd2);
        test_ops("divu_by_zero", 2'd3, 32'd7, 32'd0);
        test_ops("div_overflow", 2'd2, 32'h80000000, 32'hFFFFFFFF);
        test_ops("div_neg_by_zero", 2'd2, 32'hFFFFFFFB, 32'd0);
        test_ops("div_100_by_neg7", 2'd2, 32'd100, 32'hFFFFFFF9);
        for (int i = 0; i < 3; i++) begin
            test_ops("divu_rand", 2'd3, $urandom, $urandom_range(1, 65535));
            test_ops("div_rand", 2'd2, $urandom, $urandom);
        end
    endtask

    task automatic test_ignored_start();
        int cyc;
        bit to;
        logic [63:0] exp;
        launch(2'd1, 32'd1000, 32'd2000);
        repeat (4) @(negedge clock);
        bus.op         = 2'd3;
        bus.in_s1      = 32'd9;
        bus.in_s2      = 32'd3;
        bus.start      = 1'b1;
        bus.write_hi   = 1'b1;
        bus.write_data = 32'h12345678;
        @(negedge clock);
        bus.start    = 1'b0;
        bus.write_hi = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.hi === 32'h12345678) begin
            miscompares++;
            $display("FAIL busy_write_ignored: busy=%b hi=%h required busy=1 hi!=12345678",
                     bus.busy, bus.hi);
        end
        wait_done(cyc, to);
        exp = sb_q.pop_front();
        vectors++;
        if (to || cyc != 28) begin
            miscompares++;
            $display("FAIL second_start_latency: got %0d more cycles (timeout=%b) required 28",
                     cyc, to);
        end
        vectors++;
        if ({bus.hi, bus.lo} !== exp) begin
            miscompares++;
            $display("FAIL second_start_ignored: got hi=%h lo=%h required hi=%h lo=%h",
                     bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
        @(negedge clock);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_queued_op: done=%b busy=%b required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        logic [63:0] exp;
        launch(2'd1, 32'd123456, 32'd789);
        wait_done(cyc, to);
        exp = sb_q.pop_front();
        vectors++;
        if (to || {bus.hi, bus.lo} !== exp) begin
            miscompares++;
            $display("FAIL b2b_first: got hi=%h lo=%h required hi=%h lo=%h",
                     bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
        launch(2'd3, 32'd1000001, 32'd17);
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b required busy=1 done=0", bus.busy, bus.done);
        end
        wait_done(cyc, to);
        exp = sb_q.pop_front();
        vectors++;
        if (to || cyc != 33 || {bus.hi, bus.lo} !== exp) begin
            miscompares++;
            $display("FAIL b2b_second: got %0d cycles hi=%h lo=%h required 33 hi=%h lo=%h",
                     cyc, bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
        @(negedge clock);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] old_lo;
        int cyc;
        bit to;
        logic [63:0] exp;
        old_lo         = bus.lo;
        bus.write_hi   = 1'b1;
        bus.write_data = 32'h12345678;
        @(negedge clock);
        bus.write_hi = 1'b0;
        vectors++;
        if (bus.hi !== 32'h12345678 || bus.lo !== old_lo || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi: hi=%h lo=%h done=%b required hi=12345678 lo=%h done=0",
                     bus.hi, bus.lo, bus.done, old_lo);
        end
        bus.write_hi   = 1'b1;
        bus.write_lo   = 1'b1;
        bus.write_data = 32'hA5A55A5A;
        @(negedge clock);
        bus.write_hi = 1'b0;
        bus.write_lo = 1'b0;
        vectors++;
        if (bus.hi !== 32'hA5A55A5A || bus.lo !== 32'hA5A55A5A || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h done=%b required a5a55a5a a5a55a5a 0",
                     bus.hi, bus.lo, bus.done);
        end
        bus.write_lo   = 1'b1;
        bus.write_data = 32'hFFFF0000;
        launch(2'd1, 32'd2, 32'd3);
        bus.write_lo = 1'b0;
        vectors++;
        if (bus.lo !== 32'hA5A55A5A) begin
            miscompares++;
            $display("FAIL start_beats_write: lo=%h required a5a55a5a", bus.lo);
        end
        wait_done(cyc, to);
        exp = sb_q.pop_front();
        vectors++;
        if (to || {bus.hi, bus.lo} !== exp) begin
            miscompares++;
            $display("FAIL start_with_write_result: hi=%h lo=%h required hi=%h lo=%h",
                     bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_midop();
        launch(2'd3, 32'hFFFFFFFF, 32'd3);
        repeat (10) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0) begin
            miscompares++;
            $display("FAIL async_reset_midop: busy=%b done=%b hi=%h lo=%h required all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        sb_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        test_ops("multu_after_reset", 2'd1, 32'd3, 32'd5);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.op         = 2'd0;
        bus.in_s1      = '0;
        bus.in_s2      = '0;
        bus.write_hi   = 1'b0;
        bus.write_lo   = 1'b0;
        bus.write_data = '0;

        test_reset();
        test_multu_timing();
        test_multiply();
        test_divide();
        test_ignored_start();
        test_back_to_back();
        test_mthi_mtlo();
        test_reset_midop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit holding the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the ALU, downstream of the register file, and takes the same `in_s1`/`in_s2` operands. It drives `hi`/`lo` toward the writeback mux for MFHI/MFLO. The decoder issues `start`, and the PC is stalled while `busy` is high.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch an operation; sampled only in IDLE.
- `op`  in  2  operation select: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `in_s1`  in  32  rs operand (multiplicand or dividend).
- `in_s2`  in  32  rt operand (multiplier or divisor).
- `write_hi`  in  1  MTHI strobe.
- `write_lo`  in  1  MTLO strobe.
- `write_data`  in  32  data for MTHI/MTLO.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO receive a result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - `start` = 1: latch `op` and the operand signs. Latch |in_s1| and |in_s2| (absolute value only for signed ops; raw values for unsigned). Clear the 6-bit iteration counter and go to CALC.
- CALC: one iteration per clock, 32 iterations. When the counter reaches 31 → FIX.
  - Multiply: shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division into a 32-bit partial remainder and a 32-bit quotient, one dividend bit per cycle, MSB first.
- FIX: apply the sign fixup, write HI/LO, pulse `done`, then → IDLE.
  - MULT: 64-bit product is negated if the operand signs differ. HI = product[63:32], LO = product[31:0].
  - DIV: quotient is negated if the signs differ. Remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - Unsigned ops: no fixup.
- Divide by zero (either signedness): full latency still applies. LO = 32'hFFFFFFFF, HI = original `in_s1`.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This result falls out of the unsigned-magnitude path with no special case.
- MTHI/MTLO:
  - In IDLE with `start` = 0: `write_hi`/`write_lo` load `write_data` into HI/LO at the clock edge. Both strobes may be high in the same cycle.
  - If `start` and a write strobe are both high in IDLE, `start` wins and the write is dropped.
  - Write strobes are ignored while `busy` is high.
- `start` while busy is ignored. No queueing.
- `busy` = (state != IDLE), decoded from registered state.
- HI/LO hold their old values until FIX. MFHI/MFLO during `busy` return stale values; stalling them is the controller's job.

## Timing
- Reset (`reset_n` low, asynchronous): state = IDLE, counter = 0, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0. Applies immediately, including mid-operation. The in-flight result is discarded.
- For `start` sampled at edge N:
  - `busy` rises after edge N.
  - CALC covers edges N+1..N+32.
  - FIX is evaluated at edge N+33.
  - `hi`/`lo` take the result and `done` = 1 after edge N+33; `busy` falls at the same edge.
  - `done` clears after edge N+34.
- Back-to-back: a new `start` may be presented in the cycle after edge N+33 and is accepted at edge N+34. Minimum issue interval is 34 cycles.
- Operands need only be valid at edge N; they are not re-sampled.
- MTHI/MTLO latency is 1 edge. `done` is not pulsed for MTHI/MTLO.

## Structure
- Package `muldiv_pkg`:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`
  - state encoding `S_IDLE`, `S_CALC`, `S_FIX`
  - constant `ITERATIONS` = 32
- Sub-module `abs32`: combinational conditional two's-complement negate, `in`, `neg` → `out`. Instantiated for operand magnitude and for the result fixups.
- Everything else stays in one module: FSM, counter, accumulator/remainder datapath, HI/LO registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, `start` at edge N → after edge N+33: `hi` = 0xFFFFFFFE, `lo` = 0x00000001, `done` high exactly one cycle, `busy` high for 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- Divides:
  - DIV 0xFFFFFFF9 (−7) / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - DIVU 7 / 0 → `lo` = 0xFFFFFFFF, `hi` = 7, same 33-cycle latency.
- DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- Handshake:
  - A second `start` at edge N+5 with different operands is ignored; the result matches the first operation.
  - `write_hi` = 1, `write_data` = 0x12345678 during busy is ignored.
  - The same write in IDLE gives `hi` = 0x12345678 after 1 edge, with no `done`.
- Assert `reset_n` low mid-cycle during CALC of a DIVU → `busy`, `done`, `hi`, `lo` go to 0 immediately, before the next edge. After release, MULTU 3 × 5 gives `lo` = 15, `hi` = 0 with nominal latency.
